// File: rtl/branch_pc_unit.sv
// Fetch program counter with branch redirect and wrong-path flush sequencing.
// A taken branch loads the target and holds oFlush for FLUSH_CYCLES unstalled cycles.
module branch_pc_unit #(
   parameter int ADDR_WIDTH   = 10,
   parameter int RESET_PC     = 0,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  iStall,
   input  logic                  iBranchValid,
   input  logic                  iBranchTaken,
   input  logic                  iRelative,
   input  logic [ADDR_WIDTH-1:0] iBranchPC,
   input  logic [ADDR_WIDTH-1:0] iOffset,
   output logic [ADDR_WIDTH-1:0] oPC,
   output logic                  oFlush,
   output logic                  oRedirect
);

   typedef enum logic {
      RUN,
      FLUSH
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] PC_INIT  = ADDR_WIDTH'(RESET_PC);
   localparam logic [2:0]            CNT_INIT = 3'(FLUSH_CYCLES - 1);

   state_t                  r_state;
   state_t                  w_stateNext;
   logic [ADDR_WIDTH-1:0]   r_pc;
   logic [ADDR_WIDTH-1:0]   w_pcNext;
   logic [2:0]              r_cnt;
   logic [2:0]              w_cntNext;
   logic                    r_flush;
   logic                    w_flushNext;
   logic                    r_redirect;
   logic                    w_redirectNext;
   logic                    w_taken;
   logic [ADDR_WIDTH-1:0]   w_target;
   logic [ADDR_WIDTH-1:0]   w_pcInc;

   // Target arithmetic wraps modulo 2^ADDR_WIDTH; the carry is simply dropped.
   assign w_taken  = iBranchValid & iBranchTaken;
   assign w_target = iRelative ? (iBranchPC + iOffset) : iOffset;
   assign w_pcInc  = r_pc + 1'b1;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_state    <= RUN;
         r_pc       <= PC_INIT;
         r_cnt      <= 3'd0;
         r_flush    <= 1'b0;
         r_redirect <= 1'b0;
      end else begin
         r_state    <= w_stateNext;
         r_pc       <= w_pcNext;
         r_cnt      <= w_cntNext;
         r_flush    <= w_flushNext;
         r_redirect <= w_redirectNext;
      end
   end

   // A redirect in RUN beats a stall; in FLUSH a stall freezes everything.
   always_comb begin
      w_stateNext    = r_state;
      w_pcNext       = r_pc;
      w_cntNext      = r_cnt;
      w_flushNext    = r_flush;
      w_redirectNext = 1'b0;
      unique case (r_state)
         RUN: begin
            w_flushNext = 1'b0;
            if (w_taken) begin
               w_pcNext       = w_target;
               w_redirectNext = 1'b1;
               w_flushNext    = 1'b1;
               w_cntNext      = CNT_INIT;
               w_stateNext    = FLUSH;
            end else if (!iStall) begin
               w_pcNext = w_pcInc;
            end
         end
         FLUSH: begin
            w_flushNext = 1'b1;
            if (!iStall) begin
               w_pcNext = w_pcInc;
               if (r_cnt == 3'd0) begin
                  w_stateNext = RUN;
                  w_flushNext = 1'b0;
               end else begin
                  w_cntNext = r_cnt - 3'd1;
               end
            end
         end
         default: begin
            w_stateNext = RUN;
            w_flushNext = 1'b0;
         end
      endcase
   end

   assign oPC       = r_pc;
   assign oFlush    = r_flush;
   assign oRedirect = r_redirect;

endmodule
